// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants used by
// both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_DATA_BITS = 3'd2,
        ST_STOP_BIT  = 3'd3,
        ST_BREAK     = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam int   BAUD_CNT_W = 16;
    localparam int   BIT_IDX_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line does not look active after reset.
module uart_sync #(
    parameter logic RST_VAL = 1'b1,
    parameter int   STAGES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_reg <= {STAGES{RST_VAL}};
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frame, mid-bit sampling from a baud counter, one-cycle
// valid / framing-error pulses, and a BREAK state for a held-low line.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0]  IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    logic                  rx_s;
    uart_state_t           state_reg;
    logic [BAUD_CNT_W-1:0] baud_cnt_reg;
    logic [BIT_IDX_W-1:0]  bit_idx_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  data_reg;
    logic                  rx_valid_reg;
    logic                  frame_err_reg;

    uart_sync #(
        .RST_VAL (1'b1),
        .STAGES  (2)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    baud_cnt_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        if (!rx_s) begin
                            state_reg   <= ST_DATA_BITS;
                            bit_idx_reg <= '0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA_BITS: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg           <= '0;
                        shift_reg[bit_idx_reg] <= rx_s;
                        bit_idx_reg            <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == IDX_LAST) begin
                            state_reg <= ST_STOP_BIT;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_STOP_BIT: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        // Leaving at mid-stop leaves half a bit to catch an immediate next start.
                        if (rx_s == STOP_LEVEL) begin
                            data_reg     <= shift_reg;
                            rx_valid_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_BREAK;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_BREAK: begin
                    baud_cnt_reg <= '0;
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    baud_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign data      = data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign rx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: timing of the valid pulse,
// back-to-back frames, glitch rejection, framing error/break, reset, loopback.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int num_checks = 0;
    int num_errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = -1;
    int last_ferr_cyc = -1;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Pulse monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid || frame_err)
                check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (rx_valid) begin
                check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (frame_err) begin
                check("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
                ferr_cnt++;
                last_ferr_cyc = cyc;
            end
            prev_valid = rx_valid;
            prev_ferr  = frame_err;
        end
    end

    // Called and returns 1 time unit after a rising edge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    initial begin
        int s, s2, v1, vc, fc, r;
        logic [7:0] saved;
        logic busy_trace [0:15];

        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        repeat (2) drive_bit(1'b1);

        // Single frame 0xA5: valid on E154 = start_cyc + 155.
        send_frame(8'hA5, 1'b1, s);
        drive_bit(1'b1);
        check("a5_valid_count", valid_cnt, 32'd1);
        check("a5_valid_cycle", last_valid_cyc - s, 32'd155);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_no_ferr", ferr_cnt, 32'd0);

        // Back-to-back 0x00 then 0xFF.
        send_frame(8'h00, 1'b1, s);
        v1 = last_valid_cyc;
        check("b2b_first_data", {24'd0, data}, 32'h00);
        send_frame(8'hFF, 1'b1, s2);
        check("b2b_second_data", {24'd0, data}, 32'hFF);
        check("b2b_spacing", last_valid_cyc - v1, 32'd160);
        check("b2b_valid_count", valid_cnt, 32'd3);
        drive_bit(1'b1);

        // 4-cycle low glitch: busy visible for HALF cycles, no pulse.
        vc = valid_cnt;
        fc = ferr_cnt;
        rx = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            busy_trace[k] = rx_busy;
            if (k == 4) rx = 1'b1;
        end
        check("glitch_busy_e1", {31'd0, busy_trace[2]}, 32'd0);
        check("glitch_busy_rise", {31'd0, busy_trace[3]}, 32'd1);
        check("glitch_busy_last", {31'd0, busy_trace[10]}, 32'd1);
        check("glitch_busy_fall", {31'd0, busy_trace[11]}, 32'd0);
        check("glitch_no_valid", valid_cnt - vc, 32'd0);
        check("glitch_no_ferr", ferr_cnt - fc, 32'd0);
        check("glitch_data_kept", {24'd0, data}, 32'hFF);
        @(posedge clk);
        #1;
        drive_bit(1'b1);

        // 0x3C with a bad stop bit, then the line held low for 40 bits.
        vc = valid_cnt;
        fc = ferr_cnt;
        send_frame(8'h3C, 1'b0, s);
        repeat (40) drive_bit(1'b0);
        check("break_ferr_count", ferr_cnt - fc, 32'd1);
        check("break_ferr_cycle", last_ferr_cyc - s, 32'd155);
        check("break_no_valid", valid_cnt - vc, 32'd0);
        check("break_data_kept", {24'd0, data}, 32'hFF);
        check("break_busy_held", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        r = cyc;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("break_busy_before_exit", {31'd0, rx_busy}, 32'd1);
        check("break_exit_cycle", cyc - r, 32'd2);
        @(negedge clk);
        check("break_busy_exit", {31'd0, rx_busy}, 32'd0);
        @(posedge clk);
        #1;
        drive_bit(1'b1);

        // Reset after data bit 3 of a 0x5A frame.
        vc = valid_cnt;
        fc = ferr_cnt;
        s = cyc;
        drive_bit(1'b0);
        saved = 8'h5A;
        for (int i = 0; i < 4; i++) drive_bit(saved[i]);
        reset = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("mid_reset_data", {24'd0, data}, 32'h00);
        check("mid_reset_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_reset_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_reset_busy", {31'd0, rx_busy}, 32'd0);
        repeat (12) drive_bit(1'b1);
        check("mid_reset_no_valid", valid_cnt - vc, 32'd0);
        check("mid_reset_no_ferr", ferr_cnt - fc, 32'd0);
        send_frame(8'h81, 1'b1, s);
        drive_bit(1'b1);
        check("post_reset_data", {24'd0, data}, 32'h81);
        check("post_reset_cycle", last_valid_cyc - s, 32'd155);
        check("post_reset_count", valid_cnt - vc, 32'd1);

        // Loopback of every byte value from a bench-side transmitter.
        vc = valid_cnt;
        fc = ferr_cnt;
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1, s);
            check("loop_data", {24'd0, data}, b);
        end
        drive_bit(1'b1);
        check("loop_valid_count", valid_cnt - vc, 32'd256);
        check("loop_no_ferr", ferr_cnt - fc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
